// File: rtl/sa_nxn_ws_pkg.sv
// Shared definitions for the N x N weight-stationary systolic array.
//   sa_state_e : weight-load state machine (EMPTY, LOAD, LOADED)
//   sa_aw()    : default accumulator width, 2*DW + clog2(N)
package sa_pkg;

  typedef enum logic [1:0] {
    EMPTY  = 2'd0,
    LOAD   = 2'd1,
    LOADED = 2'd2
  } sa_state_e;

  function automatic int sa_aw(input int n, input int dw);
    return 2 * dw + $clog2(n);
  endfunction

endpackage

// File: rtl/sa_nxn_ws_pe.sv
// Single processing element of the weight-stationary array.
// Holds one weight, forwards the activation one column to the right and
// adds its product to the partial sum coming from the PE above.
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   w_en/w_in : weight load enable and value
//   a_in      : activation from the left
//   psum_in   : partial sum from above
//   a_out     : registered activation to the right
//   psum_out  : registered partial sum downwards
// Build option: SA_SIGNED_EN selects two's-complement operands.
module sa_pe #(
  parameter int DW = 8,
  parameter int AW = 18
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          w_en,
  input  logic [DW-1:0] w_in,
  input  logic [DW-1:0] a_in,
  input  logic [AW-1:0] psum_in,
  output logic [DW-1:0] a_out,
  output logic [AW-1:0] psum_out
);

  logic [DW-1:0] w_q;
  logic [AW-1:0] prod_ext;

`ifdef SA_SIGNED_EN
  logic signed [2*DW-1:0] prod;
  // Operands are sign-extended to 2*DW so the low 2*DW bits are exact.
  assign prod     = $signed({{DW{a_in[DW-1]}}, a_in}) * $signed({{DW{w_q[DW-1]}}, w_q});
  assign prod_ext = AW'(prod);
`else
  logic [2*DW-1:0] prod;
  assign prod     = {{DW{1'b0}}, a_in} * {{DW{1'b0}}, w_q};
  assign prod_ext = AW'(prod);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      w_q      <= '0;
      a_out    <= '0;
      psum_out <= '0;
    end else begin
      if (w_en) w_q <= w_in;
      a_out    <= a_in;
      psum_out <= psum_in + prod_ext;
    end
  end

endmodule

// File: rtl/sa_nxn_ws.sv
// N x N weight-stationary systolic array, matrix-vector streaming.
// Weights are loaded one row per beat; activation rows stream one per cycle
// unskewed. Inputs are skewed and outputs deskewed internally so each
// accepted row returns one result row exactly 2N cycles later.
// Ports:
//   clk, rst              : clock, synchronous active-high reset
//   w_load, w_in, w_ready : weight row beat handshake
//   a_valid, a_in, a_ready: activation row handshake
//   c_valid, c_out        : result row (c_out holds between pulses)
//   busy                  : rows still in flight
// Build option: SA_SIGNED_EN selects two's-complement arithmetic.
module sa_nxn_ws
  import sa_pkg::*;
#(
  parameter int N  = 3,
  parameter int DW = 8,
  parameter int AW = sa_aw(N, DW)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            w_load,
  input  logic [N*DW-1:0] w_in,
  output logic            w_ready,
  input  logic            a_valid,
  input  logic [N*DW-1:0] a_in,
  output logic            a_ready,
  output logic            c_valid,
  output logic [N*AW-1:0] c_out,
  output logic            busy
);

  localparam int WRW = (N > 1) ? $clog2(N) : 1;
  localparam int CW  = $clog2(2 * N + 1);

  sa_state_e        state_q, state_d;
  logic [WRW-1:0]   wrow_q, wrow_d;
  logic [CW-1:0]    inflight_q;
  logic [2*N-1:0]   vtag_q;
  logic             w_acc, a_acc, tag_out;

  logic [DW-1:0]    a_h   [N][N+1];
  logic [AW-1:0]    p_v   [N+1][N];
  logic [AW-1:0]    col_res [N];

  // Inside LOAD beats are always still pending (the last beat leaves LOAD),
  // so readiness reduces to the array being drained.
  assign w_ready = (inflight_q == '0);
  assign a_ready = (state_q == LOADED);
  assign busy    = (inflight_q != '0);
  assign w_acc   = w_load && w_ready;
  assign a_acc   = a_valid && a_ready;
  assign tag_out = vtag_q[2*N-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      wrow_q  <= '0;
    end else begin
      state_q <= state_d;
      wrow_q  <= wrow_d;
    end
  end

  // EMPTY and LOADED always sit at wrow 0, so any accepted beat there is row 0.
  always_comb begin
    state_d = state_q;
    wrow_d  = wrow_q;
    if (w_acc) begin
      case (state_q)
        LOAD: begin
          if (wrow_q == WRW'(N - 1)) begin
            state_d = LOADED;
            wrow_d  = '0;
          end else begin
            wrow_d = wrow_q + 1'b1;
          end
        end
        default: begin
          state_d = LOAD;
          wrow_d  = WRW'(1);
        end
      endcase
    end
  end

  // Inflight drops on the edge that raises c_valid, so it never exceeds 2N.
  always_ff @(posedge clk) begin
    if (rst) begin
      inflight_q <= '0;
      vtag_q     <= '0;
    end else begin
      vtag_q <= {vtag_q[2*N-2:0], a_acc};
      case ({a_acc, tag_out})
        2'b10:   inflight_q <= inflight_q + 1'b1;
        2'b01:   inflight_q <= inflight_q - 1'b1;
        default: inflight_q <= inflight_q;
      endcase
    end
  end

  // Input register plus r extra stages for row r; bubbles inject zeros.
  for (genvar r = 0; r < N; r++) begin : g_skew
    logic [DW-1:0] sk [r+1];
    logic          unused_a;

    always_ff @(posedge clk) begin
      if (rst) begin
        for (int k = 0; k <= r; k++) sk[k] <= '0;
      end else begin
        sk[0] <= a_acc ? a_in[r*DW +: DW] : '0;
        for (int k = 1; k <= r; k++) sk[k] <= sk[k-1];
      end
    end

    assign a_h[r][0] = sk[r];
    assign unused_a  = ^a_h[r][N];
  end

  for (genvar c = 0; c < N; c++) begin : g_top
    assign p_v[0][c] = '0;
  end

  for (genvar r = 0; r < N; r++) begin : g_row
    for (genvar c = 0; c < N; c++) begin : g_col
      sa_pe #(.DW(DW), .AW(AW)) u_pe (
        .clk      (clk),
        .rst      (rst),
        .w_en     (w_acc && (wrow_q == WRW'(r))),
        .w_in     (w_in[c*DW +: DW]),
        .a_in     (a_h[r][c]),
        .psum_in  (p_v[r][c]),
        .a_out    (a_h[r][c+1]),
        .psum_out (p_v[r+1][c])
      );
    end
  end

  // Column c finishes c cycles after column 0; delay it N-1-c to realign.
  for (genvar c = 0; c < N; c++) begin : g_deskew
    localparam int D = N - 1 - c;
    if (D == 0) begin : g_direct
      assign col_res[c] = p_v[N][c];
    end else begin : g_dly
      logic [AW-1:0] ds [D];
      always_ff @(posedge clk) begin
        if (rst) begin
          for (int k = 0; k < D; k++) ds[k] <= '0;
        end else begin
          ds[0] <= p_v[N][c];
          for (int k = 1; k < D; k++) ds[k] <= ds[k-1];
        end
      end
      assign col_res[c] = ds[D-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      c_valid <= 1'b0;
      c_out   <= '0;
    end else begin
      c_valid <= tag_out;
      if (tag_out) begin
        for (int c = 0; c < N; c++) c_out[c*AW +: AW] <= col_res[c];
      end
    end
  end

endmodule

// File: tb/tb_sa_nxn_ws.sv
module tb_sa_nxn_ws;
  localparam int N  = 3;
  localparam int DW = 8;
  localparam int AW = 2 * DW + $clog2(N);

  logic            clk = 1'b0;
  logic            rst, w_load, a_valid;
  logic [N*DW-1:0] w_in, a_in;
  logic            w_ready, a_ready, c_valid, busy;
  logic [N*AW-1:0] c_out;

  always #5 clk = ~clk;

  sa_nxn_ws #(.N(N), .DW(DW), .AW(AW)) dut (
    .clk     (clk),
    .rst     (rst),
    .w_load  (w_load),
    .w_in    (w_in),
    .w_ready (w_ready),
    .a_valid (a_valid),
    .a_in    (a_in),
    .a_ready (a_ready),
    .c_valid (c_valid),
    .c_out   (c_out),
    .busy    (busy)
  );

  typedef struct {
    int              due;
    logic [N*AW-1:0] res;
  } exp_t;

  int              checks = 0;
  int              failures = 0;
  int              cyc = 0;
  exp_t            q[$];
  logic [DW-1:0]   wm [N][N];
  int              m_st;      // 0 empty, 1 loading, 2 loaded
  int              m_wrow;
  logic [N*AW-1:0] last_out;
  logic            m_wacc, m_aacc;

  task automatic check(input string tag, input logic [N*AW-1:0] got, input logic [N*AW-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic longint val(input logic [DW-1:0] x);
`ifdef SA_SIGNED_EN
    return longint'($signed(x));
`else
    return longint'(x);
`endif
  endfunction

  function automatic logic [N*AW-1:0] mvm(input logic [N*DW-1:0] a);
    logic [N*AW-1:0] r;
    longint          s;
    r = '0;
    for (int c = 0; c < N; c++) begin
      s = 0;
      for (int k = 0; k < N; k++) s += val(a[k*DW +: DW]) * val(wm[k][c]);
      r[c*AW +: AW] = s[AW-1:0];
    end
    return r;
  endfunction

  function automatic logic [N*DW-1:0] pk(input int e0, input int e1, input int e2);
    return {DW'(e2), DW'(e1), DW'(e0)};
  endfunction

  function automatic logic [N*DW-1:0] rnd_row();
    return {DW'($urandom), DW'($urandom), DW'($urandom)};
  endfunction

  task automatic model_clear();
    q.delete();
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) wm[r][c] = '0;
    m_st = 0;
    m_wrow = 0;
    last_out = '0;
  endtask

  // One clock: check outputs against the model, drive inputs, advance the model.
  task automatic cycle(input logic wl, input logic [N*DW-1:0] wv,
                       input logic av, input logic [N*DW-1:0] avv);
    logic exp_cv;
    @(negedge clk);
    exp_cv = (q.size() > 0) && (q[0].due == cyc);
    if (exp_cv) begin
      last_out = q[0].res;
      void'(q.pop_front());
    end
    check("c_valid", c_valid, exp_cv);
    check("c_out",   c_out,   last_out);
    check("busy",    busy,    q.size() != 0);
    check("w_ready", w_ready, q.size() == 0);
    check("a_ready", a_ready, m_st == 2);
    w_load = wl; w_in = wv; a_valid = av; a_in = avv;
    m_wacc = wl && (q.size() == 0);
    m_aacc = av && (m_st == 2);
    @(posedge clk);
    cyc++;
    if (m_aacc) q.push_back('{due: cyc + 2 * N, res: mvm(avv)});
    if (m_wacc) begin
      if (m_st != 1) m_wrow = 0;
      for (int c = 0; c < N; c++) wm[m_wrow][c] = wv[c*DW +: DW];
      m_wrow++;
      if (m_wrow == N) begin
        m_st = 2;
        m_wrow = 0;
      end else begin
        m_st = 1;
      end
    end
  endtask

  task automatic do_reset(input int k);
    @(negedge clk);
    rst = 1'b1; w_load = 1'b0; a_valid = 1'b0;
    repeat (k) @(posedge clk);
    cyc += k;
    #1 rst = 1'b0;
    model_clear();
  endtask

  task automatic idle(input int k);
    repeat (k) cycle(1'b0, '0, 1'b0, '0);
  endtask

  // Offers each beat until accepted; gap idles before the second beat.
  task automatic load_w(input logic [N*DW-1:0] r0, input logic [N*DW-1:0] r1,
                        input logic [N*DW-1:0] r2, input int gap, input logic a_hold);
    logic [N*DW-1:0] rows [N];
    int tries;
    rows[0] = r0; rows[1] = r1; rows[2] = r2;
    for (int k = 0; k < N; k++) begin
      if (k == 1) repeat (gap) cycle(1'b0, '0, a_hold, rnd_row());
      tries = 0;
      do begin
        cycle(1'b1, rows[k], a_hold, rnd_row());
        tries++;
      end while (!m_wacc && tries < 40);
      if (!m_wacc) check("w_accept_timeout", 1'b0, 1'b1);
    end
  endtask

  logic [N*DW-1:0] w1r0, w1r1, w1r2;

  initial begin
    rst = 1'b1; w_load = 1'b0; a_valid = 1'b0; w_in = '0; a_in = '0;
    m_wacc = 1'b0; m_aacc = 1'b0;
    model_clear();
    w1r0 = pk(1, 2, 3); w1r1 = pk(4, 5, 6); w1r2 = pk(7, 8, 9);

    do_reset(2);
    idle(2);

    // Basic load and back-to-back identity-like rows.
    load_w(w1r0, w1r1, w1r2, 0, 1'b0);
    cycle(1'b0, '0, 1'b1, pk(1, 0, 0));
    cycle(1'b0, '0, 1'b1, pk(0, 2, 0));
    cycle(1'b0, '0, 1'b1, pk(0, 0, 3));
    idle(10);

    // Gapped weight load.
    do_reset(1);
    load_w(w1r0, w1r1, w1r2, 2, 1'b0);
    cycle(1'b0, '0, 1'b1, pk(1, 0, 0));
    cycle(1'b0, '0, 1'b1, pk(0, 2, 0));
    cycle(1'b0, '0, 1'b1, pk(0, 0, 3));
    idle(10);

    // a_valid held high with no weights, then during the load.
    do_reset(1);
    repeat (8) cycle(1'b0, '0, 1'b1, rnd_row());
    load_w(w1r0, w1r1, w1r2, 0, 1'b1);
    cycle(1'b0, '0, 1'b1, pk(5, 6, 7));
    idle(10);

    // Reload requested with two rows in flight; those rows keep old weights.
    cycle(1'b0, '0, 1'b1, pk(3, 1, 4));
    cycle(1'b0, '0, 1'b1, pk(1, 5, 9));
    load_w(pk(9, 8, 7), pk(6, 5, 4), pk(3, 2, 1), 0, 1'b0);
    cycle(1'b0, '0, 1'b1, pk(2, 7, 1));
    idle(10);

    // Full-scale activation: unsigned 255 or signed -1.
    load_w(w1r0, w1r1, w1r2, 0, 1'b0);
    cycle(1'b0, '0, 1'b1, pk(255, 0, 0));
    idle(8);

    // Reset with rows in flight drops them.
    cycle(1'b0, '0, 1'b1, pk(1, 1, 1));
    cycle(1'b0, '0, 1'b1, pk(2, 2, 2));
    idle(3);
    do_reset(1);
    idle(12);

    // Randomized traffic with occasional reloads.
    load_w(rnd_row(), rnd_row(), rnd_row(), 0, 1'b0);
    for (int i = 0; i < 400; i++) begin
      if (m_st != 2 || $urandom_range(0, 40) == 0)
        cycle(1'b1, rnd_row(), 1'b0, '0);
      else
        cycle(1'b0, '0, ($urandom_range(0, 9) < 7), rnd_row());
    end
    idle(2 * N + 3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sa_nxn_ws.md
# sa_nxn_ws

Parametrised N×N weight-stationary systolic array for matrix-vector streaming, successor to the fixed 3×3 array in the computation/PE area. Weights are preloaded row by row into a PE grid. Activation rows are then streamed one per cycle with no input skew required from the caller. The block skews inputs internally, deskews outputs, and returns one complete result row per accepted input row at fixed latency.

## Interface
- `N`, 3: array dimension (rows = columns = N), N ≥ 2
- `DW`, 8: activation and weight element width
- `AW`, 2*DW+$clog2(N): accumulator and output element width
- `clk`  in  1: single clock, rising edge
- `rst`  in  1: synchronous, active-high reset
- `w_load`  in  1: weight beat valid
- `w_in`  in  N*DW: one weight row; element c at bits [c*DW +: DW]
- `w_ready`  out  1: weight beat accepted this cycle when high with `w_load`
- `a_valid`  in  1: activation row valid
- `a_in`  in  N*DW: one activation row; element r at bits [r*DW +: DW]
- `a_ready`  out  1: activation row accepted this cycle when high with `a_valid`
- `c_valid`  out  1: result row valid (single-cycle pulse per row)
- `c_out`  out  N*AW: result row; element c at bits [c*AW +: AW]
- `busy`  out  1: rows in flight (inflight count ≠ 0)

## Operation
- PE(r,c) holds W[r][c]. Activation element r enters row r from the left and moves right. Partial sums move down each column.
- Result: `c_out`[c] = Σ_r a[r]·W[r][c], modulo 2^AW.
- Products are 2*DW bits, extended to AW before accumulation. Arithmetic is unsigned unless `SA_SIGNED_EN` is defined.
- FSM states:
  - EMPTY → LOAD: on first accepted weight beat.
  - LOAD → LOADED: after beat N-1.
  - LOADED → LOAD: on an accepted weight beat (full reload).
- Weight row counter `wrow` runs 0..N-1. Beat k writes PE row k. The counter holds while `w_load` is low, so a gapped load resumes where it stopped.
- `w_ready` = (state ≠ LOAD or beats pending) and inflight = 0. Weight beats are never accepted while any row is in flight.
- `a_ready` = state == LOADED. In EMPTY or LOAD, `a_valid` is ignored and nothing is queued.
- Inflight counter (0..2N):
  - +1 per accepted row, −1 per `c_valid`.
  - Simultaneous increment and decrement leaves it unchanged.
  - The counter cannot overflow because at most one row is accepted per cycle.
- Bubbles: cycles with `a_valid` low inject zeros and a cleared valid tag. Valid tags travel in a 2N-deep shift register alongside the data.

## Timing
- Latency: a row accepted at edge t produces `c_valid` high on the cycle following edge t+2N (2N = 6 for N=3). This latency is fixed and independent of gaps.
- Throughput: one row per cycle. Back-to-back rows produce back-to-back `c_valid`.
- A weight beat accepted at edge t is usable by a row accepted at edge t+1 or later, once the state is LOADED.
- Reset values:
  - `c_valid`=0, `c_out`=0, `a_ready`=0, `w_ready`=1, `busy`=0.
  - State EMPTY, `wrow`=0.
  - All weights, skew registers, partial sums and valid tags cleared.
- Reset mid-stream drops all in-flight rows. No `c_valid` appears after reset until new weights are loaded and a new row is accepted.
- `c_out` holds its last value when `c_valid` is low.

## Configuration
- `SA_SIGNED_EN` defined: weights and activations are two's complement. Products and sums are sign-extended to AW.
- `SA_SIGNED_EN` undefined: all operands are unsigned and zero-extended.

## Structure
- Package `sa_pkg`: FSM state enum (EMPTY, LOAD, LOADED) and a localparam function for the default AW.
- Sub-module `sa_pe`:
  - weight register with load enable
  - activation pass-through register
  - registered multiply-accumulate
- Top level contains:
  - generate grid of `sa_pe`
  - input skew triangles (row r delayed r)
  - output deskew triangles (column c delayed N-1-c)
  - FSM, inflight counter and valid-tag pipe

## Test plan
- N=3, DW=8. Load W rows [1,2,3], [4,5,6], [7,8,9] over three beats, then stream a = [1,0,0], [0,2,0], [0,0,3] back-to-back. Expect `c_out` = [1,2,3], [8,10,12], [21,24,27] on three consecutive `c_valid` cycles, the first 6 cycles after the first accept.
- Gapped weight load (`w_load` low for 2 cycles between beats 1 and 2): `a_ready` stays low until beat 3 lands. Results are identical to the first scenario.
- `a_valid` held high from reset with no weights loaded: `a_ready`=0 and no `c_valid` ever appears. Then load weights: the first accepted row produces exactly one result.
- Weight beat offered while 2 rows are in flight: `w_ready`=0 until `busy` falls. Those 2 in-flight results use the old weights.
- a=[0xFF,0,0] with W row 0 = [1,2,3]:
  - With `SA_SIGNED_EN`: `c_out` = [-1,-2,-3] in 18 bits.
  - Without it: `c_out` = [255,510,765].
- `rst` pulsed 3 cycles after accepting 2 rows: no `c_valid` follows. All outputs are at their reset values on the cycle after reset.
